multicycle_control: RTL and testbench

//  Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute, memory, writeback over a shared ALU and unified memory port.

---
 rtl/multicycle_control_pkg.sv | 76 +++++++
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control_alu_op_decode.sv | 32 +++
 rtl/multicycle_control.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, ALU ops,
// FSM states, instruction classes and datapath mux select encodings.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEMADDR,
    ST_MEMRD,
    ST_MEMWR,
    ST_WB,
    ST_BRANCH,
    ST_JAL,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_OP_IMM,
    CLS_OP,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] opcode);
    instr_class_e cls;
    case (opcode)
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_OP:     cls = CLS_OP;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      default:    cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle; the controller is the master.
interface multicycle_control_if #(
  parameter int ALU_OP_W = 3
);

  logic [31:0]         instr;
  logic                alu_zero;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic                addr_sel;
  logic                ir_write;
  logic                pc_write;
  logic                pc_src;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_opcode;
  logic                reg_write;
  logic [1:0]          wb_sel;
  logic                illegal;

  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_opcode, reg_write, wb_sel, illegal
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_opcode, reg_write, wb_sel, illegal
  );

endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational ALU operation decode for OP / OP-IMM instructions in EXEC.
module multicycle_control_alu_op_decode
  import multicycle_control_pkg::*;
(
  input  instr_class_e i_class,
  input  logic [2:0]   i_funct3,
  input  logic         i_funct7_5,
  output alu_op_e      o_alu_op,
  output logic         o_illegal
);

  // funct7[5] selects SUB only for register-register ops; OP-IMM has no SUBI
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    if ((i_class != CLS_OP_IMM) && (i_class != CLS_OP)) begin
      o_illegal = 1'b1;
    end else begin
      case (i_funct3)
        3'b000:  o_alu_op = ((i_class == CLS_OP) && i_funct7_5) ? ALU_SUB : ALU_ADD;
        3'b111:  o_alu_op = ALU_AND;
        3'b110:  o_alu_op = ALU_OR;
        3'b100:  o_alu_op = ALU_XOR;
        3'b010:  o_alu_op = ALU_SLT;
        3'b001:  o_alu_op = ALU_SLL;
        3'b101:  o_alu_op = ALU_SRL;
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing over a shared ALU and a single req/ready memory port.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_e       r_state;
  state_e       w_next_state;
  instr_class_e r_class;
  instr_class_e w_dec_class;
  logic [2:0]   r_funct3;
  logic         r_funct7_5;
  logic [7:0]   r_timeout;
  logic [7:0]   w_timeout_inc;
  logic [7:0]   w_timeout_next;
  logic         w_mem_state;
  logic         w_waiting;
  logic         w_timed_out;
  alu_op_e      w_exec_op;
  logic         w_exec_illegal;

  logic         w_mem_req;
  logic         w_mem_we;
  logic         w_addr_sel;
  logic         w_ir_write;
  logic         w_pc_write;
  logic         w_pc_src;
  logic [1:0]   w_src_a;
  logic [1:0]   w_src_b;
  alu_op_e      w_alu_op;
  logic         w_reg_write;
  logic [1:0]   w_wb_sel;
  logic         w_illegal;

  assign w_dec_class = classify(bus.instr[6:0]);

  multicycle_control_alu_op_decode u_alu_op_decode (
    .i_class    (r_class),
    .i_funct3   (r_funct3),
    .i_funct7_5 (r_funct7_5),
    .o_alu_op   (w_exec_op),
    .o_illegal  (w_exec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fields are captured in DECODE so later states do not depend on the IR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_class    <= CLS_NONE;
      r_funct3   <= 3'd0;
      r_funct7_5 <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_class    <= w_dec_class;
      r_funct3   <= bus.instr[14:12];
      r_funct7_5 <= bus.instr[30];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 8'd0;
    end else begin
      r_timeout <= w_timeout_next;
    end
  end

  // The counter only survives while a request keeps waiting in the same state
  always_comb begin
    w_mem_state    = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
    w_waiting      = w_mem_state && !bus.mem_ready;
    w_timeout_inc  = r_timeout + 8'd1;
    w_timed_out    = w_waiting && (w_timeout_inc == TIMEOUT_LIMIT);
    w_timeout_next = (w_waiting && !w_timed_out) ? w_timeout_inc : 8'd0;
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_src_a      = SRC_A_PC;
    w_src_b      = SRC_B_RS2;
    w_alu_op     = ALU_ADD;
    w_reg_write  = 1'b0;
    w_wb_sel     = WB_ALU;
    w_illegal    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        w_src_a   = SRC_A_PC;
        w_src_b   = SRC_B_FOUR;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = ST_DECODE;
        end else if (w_timed_out) begin
          w_next_state = ST_TRAP;
        end
      end

      ST_DECODE: begin
        w_src_a = SRC_A_PC;
        w_src_b = SRC_B_IMM;
        case (w_dec_class)
          CLS_OP_IMM, CLS_OP:  w_next_state = ST_EXEC;
          CLS_LOAD, CLS_STORE: w_next_state = ST_MEMADDR;
          CLS_BRANCH:          w_next_state = ST_BRANCH;
          CLS_JAL:             w_next_state = ST_JAL;
          default:             w_next_state = ST_TRAP;
        endcase
      end

      ST_EXEC: begin
        w_src_a      = SRC_A_RS1;
        w_src_b      = (r_class == CLS_OP) ? SRC_B_RS2 : SRC_B_IMM;
        w_alu_op     = w_exec_op;
        w_next_state = w_exec_illegal ? ST_TRAP : ST_WB;
      end

      ST_MEMADDR: begin
        w_src_a = SRC_A_RS1;
        w_src_b = SRC_B_IMM;
        if (r_funct3 != F3_WORD) begin
          w_next_state = ST_TRAP;
        end else if (r_class == CLS_LOAD) begin
          w_next_state = ST_MEMRD;
        end else begin
          w_next_state = ST_MEMWR;
        end
      end

      ST_MEMRD: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        if (bus.mem_ready) begin
          w_next_state = ST_WB;
        end else if (w_timed_out) begin
          w_next_state = ST_TRAP;
        end
      end

      ST_MEMWR: begin
        w_mem_req  = 1'b1;
        w_mem_we   = 1'b1;
        w_addr_sel = 1'b1;
        if (bus.mem_ready) begin
          w_next_state = ST_FETCH;
        end else if (w_timed_out) begin
          w_next_state = ST_TRAP;
        end
      end

      ST_WB: begin
        w_reg_write  = 1'b1;
        w_wb_sel     = (r_class == CLS_LOAD) ? WB_MEM : WB_ALU;
        w_next_state = ST_FETCH;
      end

      // Comparison is rs1 - rs2; the target was already computed in DECODE
      ST_BRANCH: begin
        w_src_a  = SRC_A_RS1;
        w_src_b  = SRC_B_RS2;
        w_alu_op = ALU_SUB;
        case (r_funct3)
          F3_BEQ: begin
            w_pc_src     = 1'b1;
            w_pc_write   = bus.alu_zero;
            w_next_state = ST_FETCH;
          end
          F3_BNE: begin
            w_pc_src     = 1'b1;
            w_pc_write   = !bus.alu_zero;
            w_next_state = ST_FETCH;
          end
          default: w_next_state = ST_TRAP;
        endcase
      end

      ST_JAL: begin
        w_pc_write   = 1'b1;
        w_pc_src     = 1'b1;
        w_reg_write  = 1'b1;
        w_wb_sel     = WB_PC4;
        w_next_state = ST_FETCH;
      end

      ST_TRAP: begin
        w_illegal = 1'b1;
      end

      default: begin
        w_next_state = ST_TRAP;
      end
    endcase
  end

  // Reset forces every output low immediately, even mid-handshake
  assign bus.mem_req    = w_mem_req   & ~reset;
  assign bus.mem_we     = w_mem_we    & ~reset;
  assign bus.addr_sel   = w_addr_sel  & ~reset;
  assign bus.ir_write   = w_ir_write  & ~reset;
  assign bus.pc_write   = w_pc_write  & ~reset;
  assign bus.pc_src     = w_pc_src    & ~reset;
  assign bus.alu_src_a  = reset ? 2'd0 : w_src_a;
  assign bus.alu_src_b  = reset ? 2'd0 : w_src_b;
  assign bus.alu_opcode = reset ? '0 : ALU_OP_W'(w_alu_op);
  assign bus.reg_write  = w_reg_write & ~reset;
  assign bus.wb_sel     = reset ? 2'd0 : w_wb_sel;
  assign bus.illegal    = w_illegal   & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: one task per scenario,
// expected control vectors written out by hand per cycle.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_if #(.ALU_OP_W(3)) bus ();

  multicycle_control #(
    .ALU_OP_W    (3),
    .MEM_TIMEOUT (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_AND  = 32'h0020F133;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_F3BAD = 32'h00003013;
  localparam logic [31:0] I_LB   = 32'h00008183;

  logic [16:0] expFetchRdy, expFetchWait, expDecode, expExecAdd, expExecSub;
  logic [16:0] expExecAnd, expWbAlu, expMemRd, expMemWr, expWbMem;
  logic [16:0] expBrTaken, expBrNot, expJal, expTrap;

  // Packing order: req we asel irw pcw pcs srcA srcB aluop rw wbsel illegal
  function automatic logic [16:0] outv(input logic req, input logic we, input logic asel,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] aop, input logic rw,
                                       input logic [1:0] wbs, input logic ill);
    return {req, we, asel, irw, pcw, pcs, sa, sb, aop, rw, wbs, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.alu_src_a, bus.alu_src_b, bus.alu_opcode, bus.reg_write, bus.wb_sel,
            bus.illegal};
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++;
    if (observed() !== 17'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %05h want %05h", observed(), 17'h0);
    end
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (observed() !== expFetchWait) begin
      bad++;
      $display("FAIL reset_release_fetch: got %05h want %05h", observed(), expFetchWait);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addi;
    logic [16:0] exp[$];
    logic        rdy[$];
    bus.instr = I_ADDI;
    bus.alu_zero = 1'b0;
    exp = '{expFetchRdy, expDecode, expExecAdd, expWbAlu, expFetchWait};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < exp.size(); k++) begin
      bus.mem_ready = rdy[k];
      #1;
      total++;
      if (observed() !== exp[k]) begin
        bad++;
        $display("FAIL addi cycle %0d: got %05h want %05h", k, observed(), exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops;
    logic [16:0] exp[$];
    logic        rdy[$];
    for (int n = 0; n < 2; n++) begin
      bus.instr = (n == 0) ? I_SUB : I_AND;
      exp = '{expFetchRdy, expDecode, (n == 0) ? expExecSub : expExecAnd, expWbAlu, expFetchWait};
      rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < exp.size(); k++) begin
        bus.mem_ready = rdy[k];
        #1;
        total++;
        if (observed() !== exp[k]) begin
          bad++;
          $display("FAIL alu_op%0d cycle %0d: got %05h want %05h", n, k, observed(), exp[k]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_load_wait;
    logic [16:0] exp[$];
    logic        rdy[$];
    bus.instr = I_LW;
    exp = '{expFetchRdy, expDecode, expExecAdd, expMemRd, expMemRd, expMemRd, expMemRd,
            expWbMem, expFetchWait};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < exp.size(); k++) begin
      bus.mem_ready = rdy[k];
      #1;
      total++;
      if (observed() !== exp[k]) begin
        bad++;
        $display("FAIL load cycle %0d: got %05h want %05h", k, observed(), exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store;
    logic [16:0] exp[$];
    logic        rdy[$];
    bus.instr = I_SW;
    exp = '{expFetchRdy, expDecode, expExecAdd, expMemWr, expMemWr, expFetchWait};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < exp.size(); k++) begin
      bus.mem_ready = rdy[k];
      #1;
      total++;
      if (observed() !== exp[k]) begin
        bad++;
        $display("FAIL store cycle %0d: got %05h want %05h", k, observed(), exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    logic [16:0] exp[$];
    logic        rdy[$];
    for (int n = 0; n < 4; n++) begin
      bus.instr    = (n < 2) ? I_BEQ : I_BNE;
      bus.alu_zero = (n == 0) || (n == 2);
      exp = '{expFetchRdy, expDecode, ((n == 0) || (n == 3)) ? expBrTaken : expBrNot, expFetchWait};
      rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < exp.size(); k++) begin
        bus.mem_ready = rdy[k];
        #1;
        total++;
        if (observed() !== exp[k]) begin
          bad++;
          $display("FAIL branch%0d cycle %0d: got %05h want %05h", n, k, observed(), exp[k]);
        end
        @(posedge clk); #1;
      end
    end
    bus.alu_zero = 1'b0;
  endtask

  task automatic test_jal;
    logic [16:0] exp[$];
    logic        rdy[$];
    bus.instr = I_JAL;
    exp = '{expFetchRdy, expDecode, expJal, expFetchWait};
    rdy = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < exp.size(); k++) begin
      bus.mem_ready = rdy[k];
      #1;
      total++;
      if (observed() !== exp[k]) begin
        bad++;
        $display("FAIL jal cycle %0d: got %05h want %05h", k, observed(), exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    logic [16:0] exp[$];
    logic        rdy[$];
    for (int n = 0; n < 3; n++) begin
      case (n)
        0: begin
          bus.instr = I_BAD;
          exp = '{expFetchRdy, expDecode, expTrap, expTrap, expTrap};
        end
        1: begin
          bus.instr = I_F3BAD;
          exp = '{expFetchRdy, expDecode, expExecAdd, expTrap, expTrap};
        end
        default: begin
          bus.instr = I_LB;
          exp = '{expFetchRdy, expDecode, expExecAdd, expTrap, expTrap};
        end
      endcase
      rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < exp.size(); k++) begin
        bus.mem_ready = rdy[k];
        #1;
        total++;
        if (observed() !== exp[k]) begin
          bad++;
          $display("FAIL illegal%0d cycle %0d: got %05h want %05h", n, k, observed(), exp[k]);
        end
        @(posedge clk); #1;
      end
      do_reset();
    end
  endtask

  task automatic test_timeout;
    // Long waits in two different states must not accumulate
    bus.instr = I_LW;
    bus.mem_ready = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    total++;
    if (observed() !== expFetchWait) begin
      bad++;
      $display("FAIL fetch_wait200: got %05h want %05h", observed(), expFetchWait);
    end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    #1;
    total++;
    if (observed() !== expMemRd) begin
      bad++;
      $display("FAIL memrd_wait100: got %05h want %05h", observed(), expMemRd);
    end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (observed() !== expWbMem) begin
      bad++;
      $display("FAIL wb_after_waits: got %05h want %05h", observed(), expWbMem);
    end
    do_reset();
    bus.mem_ready = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    total++;
    if (observed() !== expFetchWait) begin
      bad++;
      $display("FAIL fetch_wait254: got %05h want %05h", observed(), expFetchWait);
    end
    @(posedge clk); #1;
    total++;
    if (observed() !== expTrap) begin
      bad++;
      $display("FAIL timeout_trap: got %05h want %05h", observed(), expTrap);
    end
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (observed() !== expTrap) begin
      bad++;
      $display("FAIL trap_sticky: got %05h want %05h", observed(), expTrap);
    end
    do_reset();
  endtask

  task automatic test_reset_in_store;
    bus.instr = I_SW;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (observed() !== expMemWr) begin
      bad++;
      $display("FAIL memwr_waiting: got %05h want %05h", observed(), expMemWr);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.mem_req, bus.mem_we} !== 2'b00) begin
      bad++;
      $display("FAIL reset_drops_req: got %b want 00", {bus.mem_req, bus.mem_we});
    end
    @(posedge clk); #1;
    total++;
    if (observed() !== 17'h0) begin
      bad++;
      $display("FAIL reset_held: got %05h want %05h", observed(), 17'h0);
    end
    reset = 1'b0;
    #1;
    total++;
    if (observed() !== expFetchWait) begin
      bad++;
      $display("FAIL fetch_after_reset: got %05h want %05h", observed(), expFetchWait);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr     = 32'h0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    expFetchRdy  = outv(1, 0, 0, 1, 1, 0, 2'd0, 2'd2, 3'd0, 0, 2'd0, 0);
    expFetchWait = outv(1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 3'd0, 0, 2'd0, 0);
    expDecode    = outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 3'd0, 0, 2'd0, 0);
    expExecAdd   = outv(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, 0, 2'd0, 0);
    expExecSub   = outv(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 3'd1, 0, 2'd0, 0);
    expExecAnd   = outv(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 3'd2, 0, 2'd0, 0);
    expWbAlu     = outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 1, 2'd0, 0);
    expMemRd     = outv(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 0);
    expMemWr     = outv(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 0);
    expWbMem     = outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 1, 2'd1, 0);
    expBrTaken   = outv(0, 0, 0, 0, 1, 1, 2'd1, 2'd0, 3'd1, 0, 2'd0, 0);
    expBrNot     = outv(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 3'd1, 0, 2'd0, 0);
    expJal       = outv(0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 3'd0, 1, 2'd2, 0);
    expTrap      = outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1);

    test_reset();
    test_addi();
    test_alu_ops();
    test_load_wait();
    test_store();
    test_branch();
    test_jal();
    test_illegal();
    test_timeout();
    test_reset_in_store();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
